// File: rtl/wb_timing_regs.sv
// Wishbone slave with scratch registers and programmable ack wait states.
// Define WB_TIMING_STATS_EN to add the CYCLES, LAST_LAT and TXN_CNT counters.
module wb_timing_regs #(
    parameter int unsigned NREGS     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o
);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    localparam logic [5:0] IdxCtrl    = 6'd0;
    localparam logic [5:0] IdxCycles  = 6'd1;
    localparam logic [5:0] IdxLastLat = 6'd2;
    localparam logic [5:0] IdxTxnCnt  = 6'd3;

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [5:0]  idx_q, idx_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdat_q, wdat_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] scratch_q [NREGS];
    logic [31:0] scratch_d [NREGS];

    logic        hit;
    logic        enter_ack;
    logic [5:0]  t_idx;
    logic        t_we;
    logic [3:0]  t_sel;
    logic [31:0] t_dat;

`ifdef WB_TIMING_STATS_EN
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] last_lat_q, last_lat_d;
    logic [31:0] txn_q, txn_d;
    logic [3:0]  lwait_q, lwait_d;
    logic [3:0]  t_lwait;
`endif

    logic unused_adr;
    assign unused_adr = ^wbs_adr_i[1:0];

    assign hit = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
`ifdef WB_TIMING_STATS_EN
        lwait_d = lwait_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    idx_d   = wbs_adr_i[7:2];
                    we_d    = wbs_we_i;
                    sel_d   = wbs_sel_i;
                    wdat_d  = wbs_dat_i;
                    wcnt_d  = wait_q;
`ifdef WB_TIMING_STATS_EN
                    lwait_d = wait_q;
`endif
                    state_d = (wait_q != 4'd0) ? StWait : StAck;
                end
            end
            StWait: begin
                if (!(wbs_stb_i && wbs_cyc_i)) begin
                    state_d = StIdle;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                    if (wcnt_q == 4'd1) begin
                        state_d = StAck;
                    end
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // With WAIT = 0 the accept edge is also the ACK entry edge, so use the live bus fields.
    always_comb begin
        if (state_q == StIdle) begin
            t_idx   = wbs_adr_i[7:2];
            t_we    = wbs_we_i;
            t_sel   = wbs_sel_i;
            t_dat   = wbs_dat_i;
`ifdef WB_TIMING_STATS_EN
            t_lwait = wait_q;
`endif
        end else begin
            t_idx   = idx_q;
            t_we    = we_q;
            t_sel   = sel_q;
            t_dat   = wdat_q;
`ifdef WB_TIMING_STATS_EN
            t_lwait = lwait_q;
`endif
        end
    end

    assign enter_ack = (state_d == StAck);

    always_comb begin
        wait_d    = wait_q;
        scratch_d = scratch_q;
        ack_d     = enter_ack;
        rdata_d   = '0;
`ifdef WB_TIMING_STATS_EN
        cycles_d   = cycles_q + 32'd1;
        last_lat_d = last_lat_q;
        txn_d      = txn_q;
        if (enter_ack) begin
            txn_d      = txn_q + 32'd1;
            last_lat_d = 32'({1'b0, t_lwait}) + 32'd1;
        end
`endif
        if (enter_ack && t_we) begin
            if (t_idx == IdxCtrl && t_sel[0]) begin
                wait_d = t_dat[3:0];
            end
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (t_idx == 6'(i + 4)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (t_sel[b]) begin
                            scratch_d[i][8*b +: 8] = t_dat[8*b +: 8];
                        end
                    end
                end
            end
        end
        // Counter reads return the post-edge values of the edge entering ACK.
        if (enter_ack && !t_we) begin
            if (t_idx == IdxCtrl) begin
                rdata_d = {28'd0, wait_q};
            end
`ifdef WB_TIMING_STATS_EN
            if (t_idx == IdxCycles) begin
                rdata_d = cycles_d;
            end
            if (t_idx == IdxLastLat) begin
                rdata_d = last_lat_d;
            end
            if (t_idx == IdxTxnCnt) begin
                rdata_d = txn_d;
            end
`endif
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (t_idx == 6'(i + 4)) begin
                    rdata_d = scratch_q[i];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= StIdle;
            wait_q  <= '0;
            wcnt_q  <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                scratch_q[i] <= '0;
            end
`ifdef WB_TIMING_STATS_EN
            cycles_q   <= '0;
            last_lat_q <= '0;
            txn_q      <= '0;
            lwait_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            wcnt_q    <= wcnt_d;
            idx_q     <= idx_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            wdat_q    <= wdat_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            scratch_q <= scratch_d;
`ifdef WB_TIMING_STATS_EN
            cycles_q   <= cycles_d;
            last_lat_q <= last_lat_d;
            txn_q      <= txn_d;
            lwait_q    <= lwait_d;
`endif
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdata_q;

endmodule

// File: tb/tb_wb_timing_regs.sv
// Bench for wb_timing_regs: transaction-level register model checked every cycle,
// plus directed literal checks.
module tb_wb_timing_regs;

    localparam int unsigned NREGS = 4;
    localparam logic [31:0] BASE  = 32'h3000_0000;
`ifdef WB_TIMING_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        wb_clk_i  = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_we_i  = 1'b0;
    logic [3:0]  wbs_sel_i = '0;
    logic [31:0] wbs_dat_i = '0;
    logic [31:0] wbs_adr_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    wb_timing_regs #(
        .NREGS    (NREGS),
        .BASE_ADDR(BASE)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_ni(wb_rst_ni),
        .wbs_stb_i(wbs_stb_i),
        .wbs_cyc_i(wbs_cyc_i),
        .wbs_we_i (wbs_we_i),
        .wbs_sel_i(wbs_sel_i),
        .wbs_dat_i(wbs_dat_i),
        .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Rising edges since reset release; equals the CYCLES value after that edge.
    int unsigned edge_n;
    always @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) edge_n <= 0;
        else            edge_n <= edge_n + 1;
    end

    logic [3:0]  m_wait;
    logic [31:0] m_scr [NREGS];
    logic [31:0] m_txn, m_lat;
    bit          pend;
    int unsigned acc_edge, ack_at;
    bit          p_we;
    logic [5:0]  p_idx;
    logic [3:0]  p_sel;
    logic [31:0] p_dat;
    logic [3:0]  p_w;

    logic [31:0] got_dat;
    int unsigned got_edge;
    int unsigned ack_cnt = 0;
    logic        c_ack;
    logic [31:0] c_dat;
    logic [31:0] t_base;
    int unsigned cnt0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_wait = '0;
        m_txn  = '0;
        m_lat  = '0;
        pend   = 1'b0;
        for (int i = 0; i < NREGS; i++) m_scr[i] = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [5:0] idx);
        int k;
        k = int'(idx);
        if (k == 0) return {28'd0, m_wait};
        if (k == 1) return STATS ? edge_n : 32'd0;
        if (k == 2) return STATS ? m_lat : 32'd0;
        if (k == 3) return STATS ? m_txn : 32'd0;
        if (k >= 4 && k < 4 + NREGS) return m_scr[k-4];
        return 32'd0;
    endfunction

    task automatic m_write(input logic [5:0] idx, input logic [3:0] s, input logic [31:0] d);
        int k;
        k = int'(idx);
        if (k == 0 && s[0]) m_wait = d[3:0];
        if (k >= 4 && k < 4 + NREGS) begin
            for (int b = 0; b < 4; b++) if (s[b]) m_scr[k-4][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Per-cycle compare against the model's schedule of acks.
    always @(negedge wb_clk_i) begin
        c_ack = 1'b0;
        c_dat = '0;
        if (wb_rst_ni && pend && edge_n == ack_at) begin
            c_ack = 1'b1;
            pend  = 1'b0;
            m_txn = m_txn + 1;
            m_lat = 32'(p_w) + 1;
            if (p_we) m_write(p_idx, p_sel, p_dat);
            else      c_dat = m_read(p_idx);
        end
        check("ack", {31'd0, wbs_ack_o}, {31'd0, c_ack});
        check("dat_o", wbs_dat_o, c_dat);
        if (wbs_ack_o) begin
            ack_cnt++;
            got_dat  = wbs_dat_o;
            got_edge = edge_n;
        end
    end

    task automatic idle();
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = '0;
        wbs_dat_i = '0;
        wbs_adr_i = '0;
    endtask

    // Called just after a rising edge; the next edge is the accept edge.
    task automatic start(input bit w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = w;
        wbs_adr_i = a;
        wbs_sel_i = s;
        wbs_dat_i = d;
        got_edge  = 0;
        if ((a >> 8) == (BASE >> 8)) begin
            pend     = 1'b1;
            acc_edge = edge_n + 1;
            p_w      = m_wait;
            ack_at   = acc_edge + int'(p_w);
            p_we     = w;
            p_idx    = a[7:2];
            p_sel    = s;
            p_dat    = d;
        end
    endtask

    task automatic xfer(input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d);
        start(w, a, s, d);
        repeat (int'(p_w) + 1) @(posedge wb_clk_i);
        #1 idle();
        @(posedge wb_clk_i);
        #1;
    endtask

    initial begin
        t_base = BASE;
        idle();
        reset_model();
        wb_rst_ni = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #3 wb_rst_ni = 1'b1;
        @(posedge wb_clk_i);
        #1;

        xfer(1'b0, t_base + 32'h10, 4'hF, 32'h0);
        check("scr0_after_reset", got_dat, 32'h0);
        check("lat_wait0", got_edge - acc_edge + 1, 32'd1);
        xfer(1'b0, t_base, 4'hF, 32'h0);
        check("ctrl_after_reset", got_dat, 32'h0);

        xfer(1'b1, t_base + 32'h10, 4'b0101, 32'hA5A5_1234);
        xfer(1'b0, t_base + 32'h10, 4'hF, 32'h0);
        check("sel_write", got_dat, 32'h00A5_0034);
        xfer(1'b0, t_base + 32'h0C, 4'hF, 32'h0);
        check("txn_cnt_first", got_dat, STATS ? 32'd5 : 32'd0);

        xfer(1'b1, t_base, 4'h1, 32'h3);
        xfer(1'b0, t_base + 32'h14, 4'hF, 32'h0);
        check("lat_wait3", got_edge - acc_edge + 1, 32'd4);
        check("scr1_zero", got_dat, 32'h0);
        xfer(1'b0, t_base + 32'h08, 4'hF, 32'h0);
        check("last_lat", got_dat, STATS ? 32'd4 : 32'd0);
        xfer(1'b0, t_base + 32'h0C, 4'hF, 32'h0);
        check("txn_cnt_incr", got_dat, STATS ? 32'd9 : 32'd0);

        // Abort in the second wait cycle of a WAIT=5 write.
        xfer(1'b1, t_base, 4'h1, 32'h5);
        cnt0 = ack_cnt;
        start(1'b1, t_base + 32'h14, 4'hF, 32'hFFFF_FFFF);
        repeat (2) @(posedge wb_clk_i);
        #1 idle();
        pend = 1'b0;
        repeat (8) @(posedge wb_clk_i);
        #1;
        check("abort_no_ack", ack_cnt, cnt0);
        xfer(1'b1, t_base, 4'h1, 32'h0);
        xfer(1'b0, t_base + 32'h14, 4'hF, 32'h0);
        check("abort_scr1_kept", got_dat, 32'h0);
        xfer(1'b0, t_base + 32'h0C, 4'hF, 32'h0);
        check("abort_txn_cnt", got_dat, STATS ? 32'd13 : 32'd0);

        cnt0 = ack_cnt;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_adr_i = 32'h3100_0010;
        repeat (20) @(posedge wb_clk_i);
        #1 idle();
        @(posedge wb_clk_i);
        #1;
        check("miss_no_ack", ack_cnt, cnt0);
        xfer(1'b1, t_base + 32'hFC, 4'hF, 32'h1234_5678);
        xfer(1'b0, t_base + 32'hFC, 4'hF, 32'h0);
        check("idx63_ack", ack_cnt, cnt0 + 2);
        check("idx63_dat", got_dat, 32'h0);
        xfer(1'b1, t_base + 32'h04, 4'hF, 32'h1234_5678);
        xfer(1'b1, t_base + 32'h1C, 4'hF, 32'hCAFE_F00D);
        xfer(1'b0, t_base + 32'h1C, 4'hF, 32'h0);
        check("scr3_rw", got_dat, 32'hCAFE_F00D);

        // Reset while a WAIT=5 write is in flight.
        xfer(1'b1, t_base, 4'h1, 32'h5);
        xfer(1'b1, t_base + 32'h14, 4'hF, 32'h5555_AAAA);
        start(1'b1, t_base + 32'h10, 4'hF, 32'hDEAD_BEEF);
        repeat (2) @(posedge wb_clk_i);
        #1 wb_rst_ni = 1'b0;
        idle();
        reset_model();
        #1 check("ack_in_reset", {31'd0, wbs_ack_o}, 32'd0);
        repeat (2) @(posedge wb_clk_i);
        #3 wb_rst_ni = 1'b1;
        @(posedge wb_clk_i);
        #1;
        xfer(1'b0, t_base + 32'h10, 4'hF, 32'h0);
        check("rst_scr0", got_dat, 32'h0);
        xfer(1'b0, t_base + 32'h14, 4'hF, 32'h0);
        check("rst_scr1", got_dat, 32'h0);
        xfer(1'b0, t_base, 4'hF, 32'h0);
        check("rst_ctrl", got_dat, 32'h0);
        xfer(1'b0, t_base + 32'h0C, 4'hF, 32'h0);
        check("rst_txn_cnt", got_dat, STATS ? 32'd4 : 32'd0);

        repeat (100) @(posedge wb_clk_i);
        #1;
        xfer(1'b0, t_base + 32'h04, 4'hF, 32'h0);
        check("cycles_read", got_dat, STATS ? ack_at : 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
